// File: rtl/ysyx_23060208_bus_pkg.sv
// Shared definitions for the SRAM read-port arbiter: response codes,
// FSM state encoding and master indices.
package ysyx_23060208_bus_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic IFU = 1'b0;
  localparam logic LSU = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_AR    = 3'd1,
    ST_R     = 3'd2,
    ST_ERR   = 3'd3,
    ST_FLUSH = 3'd4
  } state_t;

endpackage

// File: rtl/ysyx_23060208_rd_arbiter_if.sv
// One AR/R read channel pair, used on both the master-facing and
// SRAM-facing sides of the arbiter.
interface ysyx_23060208_rd_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // A beat transfers on a rising edge where valid && ready are both high;
  // the source holds valid and its payload stable until that edge.
  logic [ADDR_W-1:0] araddr;
  logic              arvalid;
  logic              arready;
  logic [1:0]        rresp;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;
  logic              rready;

  modport master (
    output araddr, arvalid, rready,
    input  arready, rresp, rvalid, rdata
  );

  modport slave (
    input  araddr, arvalid, rready,
    output arready, rresp, rvalid, rdata
  );
endinterface

// File: rtl/ysyx_23060208_rr_pick.sv
// Combinational two-way round-robin picker: a lone requester wins, a tie
// goes to the requester that was not served last.
module ysyx_23060208_rr_pick (
  input  logic [1:0] valid,
  input  logic       last,
  output logic       gnt,
  output logic       grant_valid
);

  assign grant_valid = |valid;
  assign gnt         = (&valid) ? ~last : valid[1];

endmodule

// File: rtl/ysyx_23060208_rd_arbiter.sv
// Two-master (IFU, LSU) to one-slave read arbiter with a single outstanding
// transaction, round-robin grants and an R-phase watchdog.
module ysyx_23060208_rd_arbiter
  import ysyx_23060208_bus_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic   clk,
  input  logic   rst,
  ysyx_23060208_rd_arbiter_if.slave  m0,
  ysyx_23060208_rd_arbiter_if.slave  m1,
  ysyx_23060208_rd_arbiter_if.master s,
  output state_t dbg_state
);

  localparam int          WDOG_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int unsigned WDOG_LIM = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [WDOG_W-1:0] WDOG_END = WDOG_W'(WDOG_LIM);

  state_t            state;
  logic              gnt;
  logic              last;
  logic [ADDR_W-1:0] addr_q;
  logic [WDOG_W-1:0] wdog;
  logic              late;

  logic              pick_gnt;
  logic              pick_vld;
  logic              mg_rready;
  logic [ADDR_W-1:0] pick_addr;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_data;
  logic [1:0]        rsp_code;

  ysyx_23060208_rr_pick u_pick (
    .valid       ({m1.arvalid, m0.arvalid}),
    .last        (last),
    .gnt         (pick_gnt),
    .grant_valid (pick_vld)
  );

  assign mg_rready = (gnt == LSU) ? m1.rready : m0.rready;
  assign pick_addr = (pick_gnt == LSU) ? m1.araddr : m0.araddr;
  assign dbg_state = state;

  always_comb begin
    m0.arready = 1'b0;
    m1.arready = 1'b0;
    s.arvalid  = 1'b0;
    s.araddr   = '0;
    s.rready   = 1'b0;
    rsp_valid  = 1'b0;
    rsp_data   = '0;
    rsp_code   = RESP_OKAY;
    case (state)
      ST_IDLE: begin
        m0.arready = pick_vld && (pick_gnt == IFU);
        m1.arready = pick_vld && (pick_gnt == LSU);
      end
      ST_AR: begin
        s.arvalid = 1'b1;
        s.araddr  = addr_q;
      end
      ST_R: begin
        rsp_valid = s.rvalid;
        rsp_data  = s.rdata;
        rsp_code  = s.rresp;
        s.rready  = mg_rready;
      end
      ST_ERR: begin
        // Synthesised SLVERR; a late slave beat is absorbed meanwhile.
        rsp_valid = 1'b1;
        rsp_code  = RESP_SLVERR;
        s.rready  = 1'b1;
      end
      ST_FLUSH: s.rready = 1'b1;
      default: ;
    endcase
    m0.rvalid = rsp_valid && (gnt == IFU);
    m0.rdata  = (gnt == IFU) ? rsp_data : '0;
    m0.rresp  = (gnt == IFU) ? rsp_code : RESP_OKAY;
    m1.rvalid = rsp_valid && (gnt == LSU);
    m1.rdata  = (gnt == LSU) ? rsp_data : '0;
    m1.rresp  = (gnt == LSU) ? rsp_code : RESP_OKAY;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= ST_IDLE;
      gnt    <= IFU;
      last   <= LSU;
      addr_q <= '0;
      wdog   <= '0;
      late   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (pick_vld) begin
          addr_q <= pick_addr;
          gnt    <= pick_gnt;
          state  <= ST_AR;
        end
        ST_AR: if (s.arready) begin
          wdog  <= '0;
          state <= ST_R;
        end
        ST_R: begin
          if (s.rvalid) begin
            if (mg_rready) begin
              last  <= gnt;
              state <= ST_IDLE;
            end
          end else begin
            wdog <= wdog + WDOG_W'(1);
            if (TIMEOUT != 0 && wdog == WDOG_END) state <= ST_ERR;
          end
        end
        ST_ERR: begin
          // Once the slave's beat has been seen there is nothing left to flush.
          if (mg_rready) begin
            last  <= gnt;
            late  <= 1'b0;
            state <= (s.rvalid || late) ? ST_IDLE : ST_FLUSH;
          end else if (s.rvalid) begin
            late <= 1'b1;
          end
        end
        ST_FLUSH: if (s.rvalid) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_23060208_rd_arbiter.sv
// Bench for the read arbiter: directed scenarios followed by randomized
// two-master traffic scored against a transaction-level arbitration model.
module tb_ysyx_23060208_rd_arbiter;
  import ysyx_23060208_bus_pkg::*;

  logic   clk = 1'b0;
  logic   rst = 1'b0;
  state_t dbg_state;

  ysyx_23060208_rd_arbiter_if #(.ADDR_W(32), .DATA_W(32)) m0_if ();
  ysyx_23060208_rd_arbiter_if #(.ADDR_W(32), .DATA_W(32)) m1_if ();
  ysyx_23060208_rd_arbiter_if #(.ADDR_W(32), .DATA_W(32)) s_if ();

  ysyx_23060208_rd_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .m0        (m0_if.slave),
    .m1        (m1_if.slave),
    .s         (s_if.master),
    .dbg_state (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // master-side signals, indexed by master number
  logic [31:0] m_araddr [2];
  logic [1:0]  m_arvalid = 2'b00;
  logic [1:0]  m_rready  = 2'b00;
  logic [1:0]  m_arready;
  logic [1:0]  m_rvalid;
  logic [31:0] m_rdata [2];
  logic [1:0]  m_rresp [2];

  assign m0_if.araddr  = m_araddr[0];
  assign m0_if.arvalid = m_arvalid[0];
  assign m0_if.rready  = m_rready[0];
  assign m1_if.araddr  = m_araddr[1];
  assign m1_if.arvalid = m_arvalid[1];
  assign m1_if.rready  = m_rready[1];
  assign m_arready = {m1_if.arready, m0_if.arready};
  assign m_rvalid  = {m1_if.rvalid, m0_if.rvalid};
  assign m_rdata[0] = m0_if.rdata;
  assign m_rdata[1] = m1_if.rdata;
  assign m_rresp[0] = m0_if.rresp;
  assign m_rresp[1] = m1_if.rresp;

  // slave side: directed drive or the automatic SRAM model
  logic        sl_auto = 1'b0;
  logic        d_arready = 1'b0, d_rvalid = 1'b0;
  logic [31:0] d_rdata = '0;
  logic [1:0]  d_rresp = '0;
  logic        a_arready = 1'b0, a_rvalid = 1'b0;
  logic [31:0] a_rdata = '0;

  assign s_if.arready = sl_auto ? a_arready : d_arready;
  assign s_if.rvalid  = sl_auto ? a_rvalid  : d_rvalid;
  assign s_if.rdata   = sl_auto ? a_rdata   : d_rdata;
  assign s_if.rresp   = sl_auto ? 2'b00     : d_rresp;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  task automatic check_quiet(input string tag);
    check(tag, {m_arready, m_rvalid, s_if.arvalid, s_if.rready, |m_rdata[0], |m_rdata[1],
                |s_if.araddr, |m_rresp[0], |m_rresp[1]}, '0);
  endtask

  // ---------------- driver tasks (start and end at posedge + 1) ----------------
  task automatic slv_ar(input logic [31:0] exp_addr, input int hold);
    int t = 0;
    while (t < 20) begin
      @(negedge clk);
      if (s_if.arvalid) break;
      t++;
    end
    check("ar_seen", s_if.arvalid, 1);
    for (int i = 0; i < hold; i++) begin
      check("ar_addr_hold", s_if.araddr, exp_addr);
      check("ar_masters_quiet", {m_arready, m_rvalid}, 0);
      @(negedge clk);
    end
    check("ar_addr", {s_if.arvalid, s_if.araddr}, {1'b1, exp_addr});
    d_arready = 1'b1;
    @(posedge clk); #1 d_arready = 1'b0;
  endtask

  task automatic slv_r(input int m, input logic [31:0] data, input logic [1:0] exp_ar);
    d_rvalid = 1'b1; d_rdata = data; d_rresp = 2'b00; m_rready[m] = 1'b1;
    @(negedge clk);
    check("r_rvalid", m_rvalid, (m == 0) ? 2'b01 : 2'b10);
    check("r_rdata", m_rdata[m], data);
    check("r_rresp", m_rresp[m], 0);
    check("r_other_rdata", m_rdata[1-m], 0);
    check("r_s_rready", s_if.rready, 1);
    @(posedge clk); #1 d_rvalid = 1'b0; d_rdata = '0; m_rready[m] = 1'b0;
    @(negedge clk);
    check("r_back_idle", dbg_state, ST_IDLE);
    check("r_idle_arready", m_arready, exp_ar);
    @(posedge clk); #1;
  endtask

  task automatic request_alone(input int m, input logic [31:0] addr);
    m_araddr[m] = addr; m_arvalid[m] = 1'b1;
    @(negedge clk);
    check("req_arready", m_arready, (m == 0) ? 2'b01 : 2'b10);
    @(posedge clk); #1 m_arvalid[m] = 1'b0;
  endtask

  task automatic rand_master(input int m, input int n);
    logic got;
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      m_araddr[m] = $urandom & 32'hFFFF_FFFC;
      m_arvalid[m] = 1'b1;
      got = 1'b0;
      for (int t = 0; t < 300 && !got; t++) begin
        @(negedge clk);
        if (m_arready[m]) got = 1'b1;
        @(posedge clk); #1;
      end
      m_arvalid[m] = 1'b0;
      check("rnd_ar_taken", got, 1);
      got = 1'b0;
      for (int t = 0; t < 300 && !got; t++) begin
        m_rready[m] = 1'($urandom_range(0, 1));
        @(negedge clk);
        if (m_rvalid[m] && m_rready[m]) got = 1'b1;
        @(posedge clk); #1;
      end
      m_rready[m] = 1'b0;
      check("rnd_resp_seen", got, 1);
    end
  endtask

  // ---------------- automatic SRAM model ----------------
  logic        sl_ar_fire, sl_r_fire, sl_busy = 1'b0;
  logic [31:0] sl_ar_addr, sl_addr;
  int          sl_cnt = 0;

  always begin
    @(negedge clk);
    if (sl_auto) begin
      sl_ar_fire = s_if.arvalid && s_if.arready;
      sl_r_fire  = s_if.rvalid && s_if.rready;
      sl_ar_addr = s_if.araddr;
      @(posedge clk); #1;
      if (sl_r_fire) begin a_rvalid = 1'b0; a_rdata = '0; sl_busy = 1'b0; end
      if (sl_ar_fire) begin sl_busy = 1'b1; sl_cnt = $urandom_range(0, 2); sl_addr = sl_ar_addr; end
      if (sl_busy && !a_rvalid) begin
        if (sl_cnt == 0) begin a_rvalid = 1'b1; a_rdata = data_of(sl_addr); end
        else sl_cnt--;
      end
      a_arready = 1'($urandom_range(0, 1));
    end
  end

  // ---------------- scoreboard: transaction-level arbitration model ----------------
  logic        mon_en = 1'b0;
  logic        mdl_busy = 1'b0;
  int          mdl_last = 1;
  int          mdl_gnt = 0;
  int          mdl_w;
  int          n_rnd = 0;
  logic [1:0]  mdl_want;
  logic [31:0] exp_q[$];

  always @(negedge clk) begin
    if (mon_en) begin
      if (!mdl_busy) begin
        if (m_arvalid == 2'b11) mdl_w = (mdl_last == 0) ? 1 : 0;
        else mdl_w = m_arvalid[1] ? 1 : 0;
        mdl_want = (m_arvalid == 2'b00) ? 2'b00 : ((mdl_w == 0) ? 2'b01 : 2'b10);
        check("rnd_arready", m_arready, mdl_want);
        if (m_arvalid != 2'b00) begin
          mdl_busy = 1'b1;
          mdl_gnt  = mdl_w;
          exp_q.push_back(data_of(m_araddr[mdl_w]));
        end
      end else begin
        check("rnd_busy_arready", m_arready, 0);
        check("rnd_other_rvalid", m_rvalid[1-mdl_gnt], 0);
        if (m_rvalid[mdl_gnt] && m_rready[mdl_gnt]) begin
          check("rnd_rdata", m_rdata[mdl_gnt], exp_q.pop_front());
          check("rnd_rresp", m_rresp[mdl_gnt], 0);
          mdl_last = mdl_gnt;
          mdl_busy = 1'b0;
          n_rnd++;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    m_araddr[0] = '0; m_araddr[1] = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_quiet("reset_outputs");
    check("reset_state", dbg_state, ST_IDLE);
    @(posedge clk); #1 rst = 1'b1;

    // single IFU read, AR held for two cycles by the slave
    request_alone(0, 32'h8000_0000);
    slv_ar(32'h8000_0000, 2);
    slv_r(0, 32'h0000_0413, 2'b00);

    // simultaneous requests right after reset: IFU first, then LSU
    rst = 1'b0; @(posedge clk); #1 rst = 1'b1;
    m_araddr[0] = 32'h8000_0004; m_araddr[1] = 32'h8000_1000; m_arvalid = 2'b11;
    @(negedge clk);
    check("tie_first_gnt", m_arready, 2'b01);
    @(posedge clk); #1 m_arvalid[0] = 1'b0;
    slv_ar(32'h8000_0004, 1);
    slv_r(0, 32'h1111_0004, 2'b10);
    m_arvalid[1] = 1'b0;
    slv_ar(32'h8000_1000, 0);
    slv_r(1, 32'h2222_1000, 2'b00);

    // back-to-back contention: grants must alternate 0,1,0,1
    m_araddr[0] = 32'h8000_0100; m_araddr[1] = 32'h8000_2100; m_arvalid = 2'b11;
    @(negedge clk);
    check("b2b_first_gnt", m_arready, 2'b01);
    @(posedge clk); #1;
    for (int k = 0; k < 4; k++) begin
      if (k == 3) m_arvalid = 2'b00;
      slv_ar(m_araddr[k % 2], 0);
      slv_r(k % 2, 32'hC0DE_0000 + k, (k == 3) ? 2'b00 : ((k % 2 == 1) ? 2'b01 : 2'b10));
    end

    // response backpressure on the LSU
    request_alone(1, 32'h8000_3000);
    slv_ar(32'h8000_3000, 0);
    d_rvalid = 1'b1; d_rdata = 32'h5555_AAAA;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_s_rready", s_if.rready, 0);
      check("bp_hold", {dbg_state, m_rvalid, m_rdata[1]}, {ST_R, 2'b10, 32'h5555_AAAA});
      @(posedge clk); #1;
    end
    m_rready[1] = 1'b1;
    @(negedge clk);
    check("bp_release", {s_if.rready, m_rvalid, m_rdata[1]}, {1'b1, 2'b10, 32'h5555_AAAA});
    @(posedge clk); #1 d_rvalid = 1'b0; d_rdata = '0; m_rready[1] = 1'b0;
    @(negedge clk);
    check("bp_idle", dbg_state, ST_IDLE);
    @(posedge clk); #1;

    // watchdog: silent slave, then flush of a late beat
    request_alone(0, 32'h8000_4000);
    slv_ar(32'h8000_4000, 0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("wd_wait", {dbg_state, m_rvalid}, {ST_R, 2'b00});
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("wd_err", {dbg_state, m_rvalid, m_rresp[0], m_rdata[0], s_if.rready},
          {ST_ERR, 2'b01, 2'b10, 32'h0, 1'b1});
    m_rready[0] = 1'b1;
    m_araddr[1] = 32'h8000_5000; m_arvalid[1] = 1'b1;
    @(posedge clk); #1 m_rready[0] = 1'b0;
    @(negedge clk);
    check("wd_flush", {dbg_state, m_arready, m_rvalid, s_if.rready}, {ST_FLUSH, 2'b00, 2'b00, 1'b1});
    m_arvalid[1] = 1'b0; d_rvalid = 1'b1; d_rdata = 32'hDEAD_BEEF;
    #1 check("wd_late_discard", {m_rvalid, m_rdata[0], m_rdata[1]}, 0);
    @(posedge clk); #1 d_rvalid = 1'b0; d_rdata = '0;
    @(negedge clk);
    check("wd_back_idle", dbg_state, ST_IDLE);
    @(posedge clk); #1;

    // watchdog with the late beat arriving while the error waits for rready
    request_alone(0, 32'h8000_6000);
    slv_ar(32'h8000_6000, 0);
    repeat (8) @(posedge clk);
    #1 d_rvalid = 1'b1; d_rdata = 32'hBAD0_0001;
    @(negedge clk);
    check("late_err", {dbg_state, m_rvalid, m_rresp[0], m_rdata[0]}, {ST_ERR, 2'b01, 2'b10, 32'h0});
    @(posedge clk); #1 d_rvalid = 1'b0; d_rdata = '0; m_rready[0] = 1'b1;
    @(negedge clk);
    check("late_err_hold", {dbg_state, m_rvalid}, {ST_ERR, 2'b01});
    @(posedge clk); #1 m_rready[0] = 1'b0;
    @(negedge clk);
    check("late_exit_idle", dbg_state, ST_IDLE);
    @(posedge clk); #1;

    // asynchronous reset in the middle of R
    request_alone(0, 32'h8000_7000);
    slv_ar(32'h8000_7000, 0);
    d_rvalid = 1'b1; d_rdata = 32'h7777_0001;
    @(negedge clk);
    check("arst_pre", m_rvalid, 2'b01);
    #2 rst = 1'b0;
    #1 check_quiet("arst_quiet");
    check("arst_state", dbg_state, ST_IDLE);
    d_rvalid = 1'b0; d_rdata = '0;
    @(posedge clk); #1 rst = 1'b1;
    m_araddr[0] = 32'h8000_7004; m_araddr[1] = 32'h8000_7008; m_arvalid = 2'b11;
    @(negedge clk);
    check("arst_ifu_first", m_arready, 2'b01);
    @(posedge clk); #1 m_arvalid = 2'b00;
    slv_ar(32'h8000_7004, 0);
    slv_r(0, 32'h7777_0004, 2'b00);

    // randomized traffic against the model
    rst = 1'b0; @(posedge clk); #1 rst = 1'b1;
    sl_auto = 1'b1;
    mon_en  = 1'b1;
    fork
      rand_master(0, 25);
      rand_master(1, 25);
    join
    repeat (5) @(posedge clk);
    #1 mon_en = 1'b0;
    check("rnd_served", n_rnd, 50);
    check("rnd_q_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation exceeded its time budget");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ysyx_23060208_rd_arbiter.md
Name: ysyx_23060208_rd_arbiter

Overview:
- Two-master, one-slave read arbiter placed in front of the shared instruction/data SRAM read port, which uses AR/R valid-ready channels.
- Master 0 is the IFU and master 1 is the LSU.
- Grants are round-robin, with exactly one outstanding transaction at a time.
- The address is latched on acceptance, the read response is routed back to the granted master, and a watchdog converts a silent slave into an error response.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
TIMEOUT, 255, max cycles waiting in R for s_rvalid before error; 0 disables watchdog

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset (0 = reset asserted)
m0_araddr  in  ADDR_W  IFU read address
m0_arvalid  in  1  IFU address valid
m0_arready  out  1  IFU address accepted
m0_rresp  out  2  IFU response code
m0_rvalid  out  1  IFU data valid
m0_rdata  out  DATA_W  IFU read data
m0_rready  in  1  IFU ready for data
m1_araddr, m1_arvalid, m1_arready, m1_rresp, m1_rvalid, m1_rdata, m1_rready  same as m0, for the LSU
s_araddr  out  ADDR_W  address to SRAM
s_arvalid  out  1  address valid to SRAM
s_arready  in  1  SRAM accepts address
s_rresp  in  2  SRAM response
s_rvalid  in  1  SRAM data valid
s_rdata  in  DATA_W  SRAM data
s_rready  out  1  ready for SRAM data

Behaviour:
- FSM states: IDLE, AR, R, ERR, FLUSH.
- Registers: state, gnt (1 bit, granted master), last (1 bit, last-served master), addr_q, wdog counter (width clog2(TIMEOUT+1)).
- Reset (rst=0, async): state=IDLE, last=1 (so IFU wins the first tie), gnt=0, addr_q=0, wdog=0.
- All outputs are 0 during reset and in IDLE, except the mN_arready values defined below.
- IDLE:
  - Combinational grant: if only one mN_arvalid is high, that master wins; if both are high, the master != last wins.
  - The winner sees mN_arready=1 in the same cycle; the loser sees 0.
  - On handshake: addr_q<=winner araddr, gnt<=winner, next=AR.
  - No request: stay in IDLE.
- AR:
  - s_arvalid=1, s_araddr=addr_q; both stay stable until s_arready=1.
  - Both mN_arready=0.
  - On s_arready: next=R, wdog<=0.
  - There is no timeout in AR.
- R:
  - Pass-through routing to the granted master: mgnt_rvalid=s_rvalid, mgnt_rdata=s_rdata, mgnt_rresp=s_rresp, s_rready=mgnt_rready.
  - The non-granted master sees rvalid=0, rdata=0, rresp=0.
  - On s_rvalid && mgnt_rready: next=IDLE, last<=gnt.
  - Watchdog: wdog increments each cycle without s_rvalid. If TIMEOUT!=0 and wdog==TIMEOUT-1 with no s_rvalid, next=ERR.
- ERR:
  - mgnt_rvalid=1, mgnt_rresp=2'b10 (SLVERR), mgnt_rdata=0.
  - s_rready=1 (absorbs a late beat).
  - On mgnt_rready: next=FLUSH, last<=gnt.
  - If s_rvalid arrives in the same cycle as that rready, next=IDLE instead.
  - If s_rvalid arrives without rready, it is discarded; remember it so the exit goes to IDLE rather than FLUSH.
- FLUSH:
  - s_rready=1, no grants, mN_arready=0.
  - On s_rvalid: discard the beat, next=IDLE.
  - A slave that never answers leaves the arbiter hung; this is accepted as fatal.
- Simultaneous events: s_arready and s_rvalid in the same cycle while in AR; only s_arready is honored, and rvalid is sampled from R onward (the SRAM asserts rvalid strictly after the AR handshake).
- Master-side rules:
  - A master must hold arvalid/araddr until arready.
  - A master that deasserts arvalid in IDLE before being granted simply loses its slot; no state change occurs.
- Reset mid-transaction: returns to IDLE immediately and all outputs drop asynchronously; the outstanding slave beat is not tracked.
- Latency: one request, idle slave with 1-cycle arready and rvalid gives master handshake at T0, s_arvalid at T1, data earliest T2.

Decomposition:
- Shared package ysyx_23060208_bus_pkg:
  - RESP_OKAY=2'b00, RESP_SLVERR=2'b10.
  - FSM state encoding.
  - Master index constants IFU=0, LSU=1.
- One sub-module: ysyx_23060208_rr_pick. It is a combinational 2-way round-robin picker taking valid[1:0] and last, and outputting gnt plus a grant_valid signal.

Test Plan:
- Single IFU read: m0_arvalid at addr 0x8000_0000, SRAM returns 0x0000_0413 one cycle after the AR handshake. Required: m0_rdata=0x0000_0413, rresp=0, s_araddr stable through AR, m1_rvalid=0 throughout.
- Both masters request in the same IDLE cycle after reset (m0 addr 0x8000_0004, m1 addr 0x8000_1000). Required: IFU granted first; LSU granted on the next IDLE; m1 receives its data; last=1 afterwards.
- Back-to-back contention for 4 transactions. Required: grants alternate 0,1,0,1 and no master is served twice consecutively while the other is waiting.
- Response backpressure: m1_rready held low for 5 cycles while s_rvalid=1. Required: s_rready=0 and s_rdata/m1_rdata held for those cycles; the handshake completes on the 6th cycle.
- Watchdog with TIMEOUT=8: SRAM never asserts rvalid. Required: after 8 cycles in R, m0_rvalid=1, rresp=2'b10, rdata=0; then FLUSH; a late s_rvalid=1 with data 0xDEAD_BEEF is discarded (m0_rvalid=0); then back to IDLE.
- Async reset pulse (rst=0) mid-R. Required: all outputs 0 immediately and state=IDLE; after release, an IFU request is granted first.
